fa_response_checker: RTL and testbench
======================================

Name:
fa_response_checker

Overview:
- Self-checking stimulus/response engine for the 3-input, 2-output full-adder circuit (inputs A,B,C; outputs D=sum, E=carry).
- Drives all 8 input vectors in ascending order 000..111 and holds each for a programmable number of cycles.
- Samples D/E at the end of each hold window and compares them against a golden model.
- Reports the pass/fail result, the error count and the first failing vector. Used as the on-chip replacement for the open-loop exhaustive bench.

Parameters:
- HOLD_CYCLES, 20, clock cycles each vector is held before sampling (legal range 2..255).
- SAMPLE_OFFSET, 1, number of cycles before the end of the hold window at which D/E are sampled (legal range 1..HOLD_CYCLES-1; gives the DUT settle time).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle pulse that begins a sweep; ignored while busy=1.
- d_in  in  1  DUT sum output (D).
- e_in  in  1  DUT carry output (E).
- a_out  out  1  DUT input A, MSB of the vector.
- b_out  out  1  DUT input B.
- c_out  out  1  DUT input C, LSB of the vector.
- busy  out  1  high from the cycle after start until the sweep completes.
- done  out  1  high while in DONE; cleared by the next accepted start.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  4  number of mismatching vectors, 0..8.
- fail_valid  out  1  set on the first mismatch of a sweep.
- first_fail_vec  out  3  {A,B,C} of the first mismatch; valid when fail_valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs are 0, including a/b/c_out, err_count and first_fail_vec.
- Reset asserted mid-sweep aborts immediately with no partial result retained.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE: start=1 -> DRIVE; vec=000, hold_cnt=0, err_count=0, fail_valid=0, busy=1 on the next edge.
  - DRIVE: {a,b,c}_out=vec (registered outputs); hold_cnt increments every cycle.
  - DONE: busy=0, done=1, pass=(err_count==0). start=1 -> DRIVE with a full reinitialisation, as from IDLE.
- Sampling: sample when hold_cnt==HOLD_CYCLES-SAMPLE_OFFSET-1.
  - Expected D = A^B^C; expected E = majority(A,B,C).
  - A mismatch on either bit increments err_count by exactly 1 per vector, not per bit.
  - If fail_valid=0, first_fail_vec is latched and fail_valid is set.
- Vector advance: at hold_cnt==HOLD_CYCLES-1, hold_cnt=0 and vec=vec+1.
  - If vec==111, go to DONE instead; a/b/c_out hold 111 in DONE.
  - The 3-bit vec never wraps in the sweep.
- Latency: a sweep lasts exactly 8*HOLD_CYCLES cycles from the first DRIVE cycle to the first DONE cycle.
- start while in DRIVE: ignored, with no restart and no effect on counters.
- err_count: 4 bits, so the maximum value 8 cannot overflow; no saturation logic is required.
- d_in/e_in are treated as synchronous to clk; no synchroniser.

Decomposition:
- Shared package fa_chk_pkg holds:
  - the state enum {IDLE, DRIVE, DONE};
  - the constant NUM_VECTORS=8;
  - the vector width VEC_W=3.
- One sub-module, fa_golden_model: purely combinational, takes {A,B,C} and produces the expected {D,E}. It is reused by the bench scoreboard.
- The top contains the FSM, hold counter, vector counter and result registers.

Test Plan:
1. Ideal DUT (d_in=a^b^c, e_in=maj), HOLD_CYCLES=20, start pulse at cycle 5 -> busy high for 160 cycles; then done=1, pass=1, err_count=0, fail_valid=0.
2. DUT with E stuck-at-0 -> mismatches on vectors 011, 101, 110, 111; err_count=4, first_fail_vec=011, pass=0.
3. DUT with D inverted -> all vectors fail; err_count=8, first_fail_vec=000, no overflow.
4. start re-pulsed at cycle 50 of a sweep -> ignored; sweep still ends 160 cycles after the original start and the results are unchanged.
5. rst_n pulled low at cycle 70, asynchronously between edges -> all outputs 0 immediately; after release, start -> a clean sweep with pass=1.
6. Back-to-back: start asserted in DONE after a failing sweep, with the DUT now ideal -> err_count and fail_valid clear on the first DRIVE cycle; final pass=1.

Source files
------------

// File: rtl/fa_response_checker_pkg.sv
// Shared types and constants for the full-adder response checker.
// Holds the FSM state encoding and the vector geometry used by the checker and its golden model.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/fa_response_checker_if.sv
// Bundle of control, DUT-facing and status signals of the full-adder response checker.
// The master side is the checker; the slave side is whatever drives start and the adder outputs.
interface fa_chk_if;
  import fa_chk_pkg::*;

  logic             start;
  logic             d_in;
  logic             e_in;
  logic             a_out;
  logic             b_out;
  logic             c_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       err_count;
  logic             fail_valid;
  logic [VEC_W-1:0] first_fail_vec;

  modport master (
    input  start, d_in, e_in,
    output a_out, b_out, c_out, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

  modport slave (
    output start, d_in, e_in,
    input  a_out, b_out, c_out, busy, done, pass, err_count, fail_valid, first_fail_vec
  );

endinterface

// File: rtl/fa_response_checker_golden_model.sv
// Combinational reference full adder: {A,B,C} in, sum D and carry E out.
module fa_golden_model
  import fa_chk_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             d_o,
  output logic             e_o
);

  always_comb begin
    d_o = ^vec_i;
    e_o = (vec_i[2] & vec_i[1]) | (vec_i[2] & vec_i[0]) | (vec_i[1] & vec_i[0]);
  end

endmodule

// File: rtl/fa_response_checker.sv
// Exhaustive stimulus/response checker for a full adder: sweeps {A,B,C} 000..111,
// samples D/E near the end of each hold window and records error count and first failing vector.
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter int HOLD_CYCLES   = 20,  // 2..255
  parameter int SAMPLE_OFFSET = 1    // 1..HOLD_CYCLES-1
) (
  input  logic     clk,
  input  logic     rst_n,
  fa_chk_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(HOLD_CYCLES - SAMPLE_OFFSET - 1);
  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(NUM_VECTORS - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0] first_fail_q, first_fail_d;

  logic exp_d, exp_e;
  logic start_acc, sample_hit, last_hit, mismatch;

  fa_golden_model u_golden (
    .vec_i (vec_q),
    .d_o   (exp_d),
    .e_o   (exp_e)
  );

  // start is only honoured outside a sweep; a re-pulse during DRIVE has no effect
  always_comb begin
    start_acc  = bus.start && (state_q != DRIVE);
    sample_hit = (state_q == DRIVE) && (hold_cnt_q == SAMPLE_CNT);
    last_hit   = (state_q == DRIVE) && (hold_cnt_q == LAST_CNT);
    mismatch   = (bus.d_in != exp_d) || (bus.e_in != exp_e);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DRIVE;
      DRIVE:   if (last_hit && (vec_q == LAST_VEC)) state_d = DONE;
      DONE:    if (bus.start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == DRIVE);
    bus.done = (state_q == DONE);
    bus.pass = (state_q == DONE) && (err_cnt_q == 4'd0);
  end

  // One error per vector regardless of how many bits disagree; the vector freezes at 111 into DONE
  always_comb begin
    vec_d        = vec_q;
    hold_cnt_d   = hold_cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    if (start_acc) begin
      vec_d        = '0;
      hold_cnt_d   = '0;
      err_cnt_d    = '0;
      fail_valid_d = 1'b0;
      first_fail_d = '0;
    end else if (state_q == DRIVE) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
      if (sample_hit && mismatch) begin
        err_cnt_d = err_cnt_q + 4'd1;
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          first_fail_d = vec_q;
        end
      end
      if (last_hit) begin
        hold_cnt_d = '0;
        if (vec_q != LAST_VEC) vec_d = vec_q + VEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q        <= '0;
      hold_cnt_q   <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      vec_q        <= vec_d;
      hold_cnt_q   <= hold_cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign bus.a_out          = vec_q[2];
  assign bus.b_out          = vec_q[1];
  assign bus.c_out          = vec_q[0];
  assign bus.err_count      = err_cnt_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker: emulates ideal and faulty full adders around the checker
// and scores each sweep's final result against a per-sweep expectation built from the fault mode.
module tb_fa_response_checker;
  import fa_chk_pkg::*;

  localparam int HOLD = 20;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] ffv;
  } exp_t;

  logic clk;
  logic rst_n;
  int   fault_mode;  // 0 ideal, 1 E stuck-at-0, 2 D inverted
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  logic [2:0] dut_vec;
  logic       emu_d, emu_e;
  logic [2:0] gm_vec;
  logic       gm_d, gm_e;

  fa_chk_if bus ();

  fa_response_checker #(
    .HOLD_CYCLES   (HOLD),
    .SAMPLE_OFFSET (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  fa_golden_model u_gm (
    .vec_i (gm_vec),
    .d_o   (gm_d),
    .e_o   (gm_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dut_vec = {bus.a_out, bus.b_out, bus.c_out};
    emu_d   = ^dut_vec;
    emu_e   = (dut_vec[2] & dut_vec[1]) | (dut_vec[2] & dut_vec[0]) | (dut_vec[1] & dut_vec[0]);
    if (fault_mode == 2) emu_d = ~emu_d;
    if (fault_mode == 1) emu_e = 1'b0;
  end

  assign bus.d_in = emu_d;
  assign bus.e_in = emu_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.a_out, bus.b_out, bus.c_out, bus.busy, bus.done, bus.pass,
                bus.err_count, bus.fail_valid, bus.first_fail_vec});
  endfunction

  task automatic run_sweep(input int mode, input int repulse_at, input int abort_at);
    exp_t       e;
    exp_t       got;
    int         k;
    bit         fin;
    logic [2:0] cur;
    logic       ee;
    fault_mode = mode;
    e.err = 4'd0;
    e.fv  = 1'b0;
    e.ffv = 3'd0;
    for (int v = 0; v < 8; v++) begin
      cur = 3'(v);
      ee  = (cur[2] & cur[1]) | (cur[2] & cur[0]) | (cur[1] & cur[0]);
      if ((mode == 2) || (mode == 1 && ee)) begin
        e.err = e.err + 4'd1;
        if (!e.fv) begin
          e.fv  = 1'b1;
          e.ffv = cur;
        end
      end
    end
    e.pass = (e.err == 4'd0);
    sb_q.push_back(e);

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("err_cleared", 32'(bus.err_count), 32'd0);
    chk("fail_valid_cleared", 32'(bus.fail_valid), 32'd0);

    k   = 0;
    fin = 1'b0;
    while (!fin && k < 4000) begin
      if (abort_at >= 0 && k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", all_outs(), 32'd0);
        void'(sb_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k < 8 * HOLD && (k % HOLD) == HOLD / 2)
        chk("drive_vec", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'(k / HOLD));
      bus.start = (repulse_at >= 0 && k == repulse_at);
      @(negedge clk);
      k++;
      if (bus.done) fin = 1'b1;
    end
    bus.start = 1'b0;
    got = sb_q.pop_front();
    if (!fin) begin
      chk("sweep_timeout", 32'd0, 32'd1);
      return;
    end
    chk("sweep_len", 32'(k), 32'(8 * HOLD));
    chk("busy_in_done", 32'(bus.busy), 32'd0);
    chk("pass", 32'(bus.pass), 32'(got.pass));
    chk("err_count", 32'(bus.err_count), 32'(got.err));
    chk("fail_valid", 32'(bus.fail_valid), 32'(got.fv));
    if (got.fv) chk("first_fail_vec", 32'(bus.first_fail_vec), 32'(got.ffv));
    chk("vec_hold_111", 32'({bus.a_out, bus.b_out, bus.c_out}), 32'd7);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    fault_mode = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    gm_vec     = 3'd0;

    for (int v = 0; v < 8; v++) begin
      logic [2:0] t;
      t      = 3'(v);
      gm_vec = t;
      #1;
      chk("golden_d", 32'(gm_d), 32'(t[2] ^ t[1] ^ t[0]));
      chk("golden_e", 32'(gm_e), 32'((t[2] & t[1]) | (t[2] & t[0]) | (t[1] & t[0])));
    end

    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_outs", all_outs(), 32'd0);

    run_sweep(0, -1, -1);  // ideal
    run_sweep(1, -1, -1);  // E stuck-at-0
    run_sweep(1, 50, -1);  // re-pulsed start ignored
    run_sweep(2, -1, -1);  // D inverted: all 8 fail
    run_sweep(0, -1, -1);  // back-to-back from a failing DONE
    run_sweep(0, -1, 70);  // reset mid-sweep
    chk("idle_after_abort", all_outs(), 32'd0);
    run_sweep(0, -1, -1);  // clean sweep after reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
